// File: rtl/tape_pkg.sv
// Shared constants and FSM encoding for the ADC cassette slicer.
package tape_pkg;

  localparam int ADC_DW         = 12;
  localparam int HIST_LOG2      = 9;
  localparam int THRESH_DEFAULT = 100;

  // A low analog level is reported as a 1 on the cassette line.
  localparam logic CAS_INVERT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WT,
    ST_UPD,
    ST_CMP
  } slicer_state_t;

endpackage

// File: rtl/slicer_hist_ram.sv
// Sample history store: simple dual-port RAM, one write port, registered read.
module slicer_hist_ram #(
  parameter int DW = 12,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: no reset here on purpose; a reset on the array or read register
  // would stop the tools mapping it onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/adc_tape_slicer.sv
// Turns the ADC sample stream into a one-bit cassette signal using a
// hysteresis comparator around a 512-sample running average.
module adc_tape_slicer
  import tape_pkg::*;
#(
  parameter int DW        = tape_pkg::ADC_DW,
  parameter int HIST_LOG2 = tape_pkg::HIST_LOG2,
  parameter int THRESH    = tape_pkg::THRESH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_sync,
  output logic          cas_bit,
  output logic [DW-1:0] avg,
  output logic          sample_stb,
  output logic          overrun
);

  localparam int TW = DW + HIST_LOG2;
  localparam int CW = DW + 2;

  slicer_state_t state_q, state_d;

  logic                 sync_q;
  logic [DW-1:0]        sample_q;
  logic [DW-1:0]        pend_q;
  logic                 pend_v_q;
  logic                 overrun_q;
  logic [TW-1:0]        total_q;
  logic [HIST_LOG2-1:0] ptr_q;
  logic [HIST_LOG2:0]   fill_q;
  logic [DW-1:0]        avg_q;
  logic                 cas_q;

  logic                 sync_event;
  logic                 ram_we;
  logic [DW-1:0]        ram_rdata;
  logic [DW-1:0]        old_eff;
  logic [TW-1:0]        total_d;
  logic [DW-1:0]        avg_d;
  logic [CW-1:0]        lo_lim, hi_lim;
  logic                 cas_d;

  assign sync_event = sync_q ^ adc_sync;

  slicer_hist_ram #(
    .DW (DW),
    .AW (HIST_LOG2)
  ) u_hist (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ptr_q),
    .wdata_i (sample_q),
    .raddr_i (ptr_q),
    .rdata_o (ram_rdata)
  );

  // Until the history is full the RAM holds stale data that was never added.
  assign old_eff = fill_q[HIST_LOG2] ? ram_rdata : '0;
  assign total_d = total_q - TW'(old_eff) + TW'(sample_q);
  assign avg_d   = total_d[TW-1:HIST_LOG2];
  assign lo_lim  = CW'(sample_q) + CW'(THRESH);
  assign hi_lim  = CW'(avg_d) + CW'(THRESH);

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cas_d = cas_q;
    if (lo_lim < CW'(avg_d))            cas_d = CAS_INVERT;
    else if (CW'(sample_q) > hi_lim)    cas_d = ~CAS_INVERT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pend_v_q || sync_event) state_d = ST_RD;
      ST_RD:   state_d = ST_WT;
      ST_WT:   state_d = ST_UPD;
      ST_UPD:  state_d = ST_CMP;
      ST_CMP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sample_stb = (state_q == ST_CMP);
    ram_we     = (state_q == ST_UPD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 1'b0;
      sample_q  <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      overrun_q <= 1'b0;
      total_q   <= '0;
      ptr_q     <= '0;
      fill_q    <= '0;
      avg_q     <= '0;
      cas_q     <= 1'b0;
    end else begin
      sync_q <= adc_sync;

      // A pending sample always goes first; a coincident event refills the slot.
      if (state_q == ST_IDLE) begin
        if (pend_v_q) begin
          sample_q <= pend_q;
          if (sync_event) pend_q   <= adc_data;
          else            pend_v_q <= 1'b0;
        end else if (sync_event) begin
          sample_q <= adc_data;
        end
      end else if (sync_event) begin
        if (!pend_v_q) begin
          pend_q   <= adc_data;
          pend_v_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      // Results are loaded on entry to CMP so they are visible with sample_stb.
      if (state_q == ST_UPD) begin
        total_q <= total_d;
        ptr_q   <= ptr_q + HIST_LOG2'(1);
        if (!fill_q[HIST_LOG2]) fill_q <= fill_q + (HIST_LOG2+1)'(1);
        avg_q   <= avg_d;
        cas_q   <= cas_d;
      end
    end
  end

  assign cas_bit = cas_q;
  assign avg     = avg_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_tape_slicer.sv
// Scoreboard bench for adc_tape_slicer: a reference average/hysteresis model
// queues expected results, a monitor pops them on every sample_stb.
module tb_adc_tape_slicer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] adc_data;
  logic        adc_sync;
  logic        cas_bit;
  logic [11:0] avg;
  logic        sample_stb;
  logic        overrun;

  always #5 clk = ~clk;

  adc_tape_slicer dut (
    .clk        (clk),
    .reset      (reset),
    .adc_data   (adc_data),
    .adc_sync   (adc_sync),
    .cas_bit    (cas_bit),
    .avg        (avg),
    .sample_stb (sample_stb),
    .overrun    (overrun)
  );

  typedef struct {
    logic [11:0] avg;
    logic        cas;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference model of the running average and hysteresis slicer.
  logic [11:0] m_hist [512];
  int          m_ptr;
  int          m_fill;
  int          m_total;
  logic        m_cas;

  task automatic model_reset();
    m_ptr = 0; m_fill = 0; m_total = 0; m_cas = 1'b0;
  endtask

  task automatic model_push(input logic [11:0] d);
    int   old_v;
    int   a;
    exp_t e;
    old_v = (m_fill == 512) ? int'(m_hist[m_ptr]) : 0;
    m_total = m_total - old_v + int'(d);
    m_hist[m_ptr] = d;
    m_ptr = (m_ptr + 1) % 512;
    if (m_fill < 512) m_fill++;
    a = m_total / 512;
    if (int'(d) + 100 < a)      m_cas = 1'b1;
    else if (int'(d) > a + 100) m_cas = 1'b0;
    e.avg = 12'(a);
    e.cas = m_cas;
    exp_q.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset && sample_stb) begin
      if (exp_q.size() == 0) begin
        check("stray_stb", 32'(sample_stb), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("avg", 32'(avg), 32'(mon_e.avg));
        check("cas_bit", 32'(cas_bit), 32'(mon_e.cas));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cas"}, 32'(cas_bit), 32'd0);
    check({tag, "_avg"}, 32'(avg), 32'd0);
    check({tag, "_stb"}, 32'(sample_stb), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    adc_sync = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
  endtask

  // One sample per call; called on a negedge with the DUT idle.
  task automatic send(input logic [11:0] d);
    int lat;
    model_push(d);
    adc_data = d;
    adc_sync = ~adc_sync;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (sample_stb) begin
        lat = n;
        break;
      end
    end
    check("stb_latency", 32'(lat), 32'd4);
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2;
    reset    = 1'b1;
    adc_sync = 1'b0;
    adc_data = 12'd0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Data wiggles without sync toggles must not produce events.
    for (int i = 0; i < 8; i++) begin
      adc_data = 12'($urandom_range(0, 4095));
      @(negedge clk);
      check("idle_stb", 32'(sample_stb), 32'd0);
    end
    check_reset_outputs("idle");

    // Fill phase: avg ramps by 4 per sample of 2048.
    for (int k = 0; k < 512; k++) send(12'd2048);
    check("fill_avg", 32'(avg), 32'd2048);
    check("fill_cas", 32'(cas_bit), 32'd0);

    // Hysteresis around the steady average.
    send(12'd1900);
    check("low_cas", 32'(cas_bit), 32'd1);
    check("low_avg", 32'(avg), 32'd2047);
    send(12'd2000);
    check("band_cas", 32'(cas_bit), 32'd1);
    send(12'd2200);
    check("high_cas", 32'(cas_bit), 32'd0);

    // Alternating input wraps the history pointer twice.
    for (int i = 0; i < 1100; i++) send((i % 2) ? 12'd3000 : 12'd1000);
    check("alt_settle", 32'((avg >= 12'd1999) && (avg <= 12'd2001)), 32'd1);
    check("alt_ovr", 32'(overrun), 32'd0);

    // Three toggles on consecutive cycles: two processed, one dropped.
    s1 = -1;
    s2 = -1;
    model_push(12'd500);
    adc_data = 12'd500;
    adc_sync = ~adc_sync;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (sample_stb) begin
        if (s1 < 0) s1 = n;
        else if (s2 < 0) s2 = n;
      end
      if (n == 1) begin
        model_push(12'd3500);
        adc_data = 12'd3500;
        adc_sync = ~adc_sync;
      end else if (n == 2) begin
        adc_data = 12'd100;
        adc_sync = ~adc_sync;
      end
    end
    check("ovr_stb1", 32'(s1), 32'd4);
    check("ovr_stb2", 32'(s2), 32'd9);
    check("ovr_set", 32'(overrun), 32'd1);
    send(12'd2000);
    send(12'd2000);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of UPD after 300 samples; stale RAM must be ignored.
    do_reset();
    for (int i = 0; i < 300; i++) send(12'd3000);
    adc_data = 12'd2048;
    adc_sync = ~adc_sync;
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    adc_sync = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_release");
    for (int k = 0; k < 512; k++) send(12'd2048);
    check("refill_avg", 32'(avg), 32'd2048);
    check("refill_cas", 32'(cas_bit), 32'd0);

    repeat (4) @(negedge clk);
    check("queue_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
